mod_counter: RTL

Parametrised up/down counter with programmable modulus, wrap or saturate mode, synchronous load/clear, an enable prescaler and terminal-count/overflow reporting. Next-generation replacement for the fixed 8-bit enable counter. Used wherever timers, event counters and modulo sequencers are needed. Single clock domain, fully synchronous.

---
 rtl/mod_counter_pkg.sv | 7 +
 rtl/mod_counter_if.sv | 14 +
 rtl/mod_counter_tick_prescaler.sv | 26 ++
 rtl/mod_counter.sv | 50 +++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg: shared direction type and prescaler sizing helper for mod_counter
package mod_counter_pkg;
  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;
  function automatic int pre_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction
endpackage

// File: rtl/mod_counter_if.sv
// mod_counter_if: control inputs and count/status outputs of mod_counter
interface mod_counter_if #(parameter int WIDTH = 8);
  logic enable;
  logic up;
  logic clear;
  logic load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic tc;
  logic overflow;
  logic underflow;
  modport master(output enable, up, clear, load, load_value, input count, tc, overflow, underflow);
  modport slave(input enable, up, clear, load, load_value, output count, tc, overflow, underflow);
endinterface

// File: rtl/mod_counter_tick_prescaler.sv
// tick_prescaler: emits a one-cycle step every PRESCALE enabled cycles
module tick_prescaler
  import mod_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic step
);
  if (PRESCALE == 1) begin : g_direct
    logic unused;
    assign unused = ^{clk, reset, restart};
    assign step = enable;
  end else begin : g_cnt
    localparam int PW = pre_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
    logic [PW-1:0] pre_cnt;
    always_ff @(posedge clk)
      if (reset || restart) pre_cnt <= '0;
      else if (enable) pre_cnt <= (pre_cnt == LAST) ? '0 : pre_cnt + 1'b1;
    assign step = enable && (pre_cnt == LAST);
  end
endmodule

// File: rtl/mod_counter.sv
// mod_counter: up/down modulo counter with wrap/saturate, load/clear, prescaler and tc/overflow flags
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter longint unsigned MAX_VALUE = (64'd1 << WIDTH) - 64'd1,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input logic clk,
  input logic reset,
  mod_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VALUE);
  logic step, up_step, at_max, at_min;
  logic [WIDTH-1:0] clamped, up_nx, dn_nx;
  dir_e dir;
  tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk(clk),
    .reset(reset),
    .enable(bus.enable),
    .restart(bus.clear | bus.load),
    .step(step)
  );
  assign dir = dir_e'(bus.up);
  assign up_step = (dir == DIR_UP);
  // Boundaries are compared explicitly since MAX_VALUE need not be all ones
  always_comb begin
    at_max = (bus.count == MAXV);
    at_min = (bus.count == '0);
    clamped = (bus.load_value > MAXV) ? MAXV : bus.load_value;
    up_nx = at_max ? ((SATURATE != 0) ? MAXV : '0) : bus.count + 1'b1;
    dn_nx = at_min ? ((SATURATE != 0) ? '0 : MAXV) : bus.count - 1'b1;
  end
  always_ff @(posedge clk)
    if (reset || bus.clear) begin
      bus.count <= '0;
      bus.tc <= 1'b0;
      bus.overflow <= 1'b0;
      bus.underflow <= 1'b0;
    end else if (bus.load) begin
      bus.count <= clamped;
      bus.tc <= 1'b0;
    end else begin
      if (step) bus.count <= up_step ? up_nx : dn_nx;
      bus.tc <= step && (up_step ? at_max : at_min);
      bus.overflow <= bus.overflow | (step && up_step && at_max);
      bus.underflow <= bus.underflow | (step && !up_step && at_min);
    end
endmodule
